// File: rtl/handshake_constant_arbiter_pkg.sv
// Shared definitions for the handshake_* arbiter family: slot-index width
// computation and the arbiter "no winner" encoding.
package handshake_constant_arbiter_pkg;

    // Width of a requester/slot index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Arbiter result flag: ARB_NONE means no requester was valid.
    typedef enum logic {
        ARB_NONE = 1'b0,
        ARB_HIT  = 1'b1
    } arb_any_e;

    // Index reported by an arbiter when it has no winner.
    localparam int ARB_NONE_IDX = 0;

endpackage

// File: rtl/handshake_constant_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping,
// and grants the first asserted bit. The pointer register lives in the parent.
module handshake_constant_arbiter_rr_arbiter
    import handshake_constant_arbiter_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    localparam int IDX_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [IDX_WIDTH-1:0] idx,
    output arb_any_e             any
);

    int pos;

    // Priority scan from ptr; the first hit stops further grants.
    always_comb begin
        gnt = '0;
        idx = IDX_WIDTH'(ARB_NONE_IDX);
        any = ARB_NONE;
        pos = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (any == ARB_NONE && req[pos]) begin
                gnt[pos] = 1'b1;
                idx      = IDX_WIDTH'(pos);
                any      = ARB_HIT;
            end
        end
    end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin constant issuer: each accepted control token emits the
// granted requester's programmable constant and index on one registered
// elastic output channel.
module handshake_constant_arbiter
    import handshake_constant_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int IDX_WIDTH  = idx_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ctrl_valid,
    output logic [NUM_REQ-1:0]    ctrl_ready,
    input  logic                  cfg_we,
    input  logic [IDX_WIDTH-1:0]  cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_idx,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] slot;
    logic [IDX_WIDTH-1:0]               rr_ptr;
    logic [NUM_REQ-1:0]                 gnt;
    logic [IDX_WIDTH-1:0]               gnt_idx;
    arb_any_e                           arb_any;
    logic                               load;
    logic                               winner;
    logic                               take;

    handshake_constant_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (ctrl_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (arb_any)
    );

    // Output stage can accept a new token when empty or being drained.
    assign load   = !outs_valid || outs_ready;
    assign winner = (arb_any == ARB_HIT);
    assign take   = load && winner;
    assign ctrl_ready = (take && !rst) ? gnt : '0;

    // Pointer moves just past the granted requester, wrapping to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= (gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Constant slots; out-of-range addresses match no slot and are dropped.
    // A write lands at the edge, so a same-cycle grant still sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cfg_addr == IDX_WIDTH'(i)) slot[i] <= cfg_data;
            end
        end
    end

    // Single elastic output register; holds while stalled, empties on no winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outs       <= '0;
            outs_idx   <= '0;
            outs_valid <= 1'b0;
        end else if (load) begin
            if (winner) begin
                outs       <= slot[gnt_idx];
                outs_idx   <= gnt_idx;
                outs_valid <= 1'b1;
            end else begin
                outs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Directed and randomized checks for handshake_constant_arbiter.
module tb_handshake_constant_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ctrl_valid;
    logic [N-1:0]  ctrl_ready;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [DW-1:0] outs;
    logic [IW-1:0] outs_idx;
    logic          outs_valid;
    logic          outs_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    handshake_constant_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .outs       (outs),
        .outs_idx   (outs_idx),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [IW-1:0] a, input logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] slot_m [N];
    logic [DW-1:0] m_slot [N];
    int            cnt [N];
    int            waitc [N];
    logic [N-1:0]  pend;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] m_outs;
    logic [IW-1:0] m_idx;
    logic          m_valid;
    int            m_ptr;
    int            g;
    int            p;
    bit            found;
    bit            m_load;
    int            n_grant;
    int            n_cons;

    initial begin
        rst = 1'b1; ctrl_valid = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_data = '0; outs_ready = 1'b1;
        #2;
        chk("rst_valid", outs_valid, 0);
        chk("rst_outs",  outs, 0);
        chk("rst_idx",   outs_idx, 0);
        chk("rst_rdy",   ctrl_ready, 0);
        step(); step();
        rst = 1'b0;

        // 1: program slots, single token from requester 0
        slot_m[0] = 32'h6B8A8F0B; slot_m[1] = 32'h11111111;
        slot_m[2] = 32'h22222222; slot_m[3] = 32'h33333333;
        for (int i = 0; i < N; i++) cfg_wr(IW'(i), slot_m[i]);
        ctrl_valid = 4'b0001;
        #1;
        chk("t1_rdy", ctrl_ready, 4'b0001);
        step();
        ctrl_valid = '0;
        chk("t1_outs",  outs, 32'h6B8A8F0B);
        chk("t1_idx",   outs_idx, 0);
        chk("t1_valid", outs_valid, 1);

        // Bring pointer back to 0 via requester 3
        ctrl_valid = 4'b1000;
        step();
        ctrl_valid = '0;
        chk("t1b_outs", outs, 32'h33333333);
        chk("t1b_idx",  outs_idx, 3);

        // 2: all requesters valid, full throughput
        for (int i = 0; i < N; i++) cnt[i] = 0;
        ctrl_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            for (int i = 0; i < N; i++) cnt[i] += int'(ctrl_ready[i]);
            step();
            chk("t2_idx",  outs_idx, c % 4);
            chk("t2_outs", outs, slot_m[c % 4]);
        end
        for (int i = 0; i < N; i++) chk("t2_cnt", cnt[i], 2);

        // 3: output stalled, no accepts, output stable
        ctrl_valid = 4'b0110;
        outs_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_rdy",   ctrl_ready, 0);
            chk("t3_outs",  outs, 32'h33333333);
            chk("t3_idx",   outs_idx, 3);
            chk("t3_valid", outs_valid, 1);
            step();
        end
        outs_ready = 1'b1;
        #1;
        chk("t3_rdy_rel", ctrl_ready, 4'b0010);
        step();
        chk("t3_idx_rel",  outs_idx, 1);
        chk("t3_outs_rel", outs, 32'h11111111);

        // 4: config write to the slot being granted in the same cycle
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 32'hDEADBEEF;
        #1;
        chk("t4_rdy", ctrl_ready, 4'b0100);
        step();
        cfg_we = 1'b0;
        chk("t4_old", outs, 32'h22222222);
        chk("t4_idx", outs_idx, 2);
        ctrl_valid = 4'b0100;
        #1;
        chk("t4_rdy2", ctrl_ready, 4'b0100);
        step();
        chk("t4_new", outs, 32'hDEADBEEF);

        // Config write while output held
        ctrl_valid = '0; outs_ready = 1'b0;
        cfg_wr(2'd2, 32'h44444444);
        chk("hold_outs",  outs, 32'hDEADBEEF);
        chk("hold_valid", outs_valid, 1);
        // Load without winner: valid drops, data holds
        outs_ready = 1'b1;
        step();
        chk("nowin_valid", outs_valid, 0);
        chk("nowin_outs",  outs, 32'hDEADBEEF);
        chk("nowin_idx",   outs_idx, 2);
        ctrl_valid = 4'b0100;
        step();
        ctrl_valid = '0;
        chk("t4_upd", outs, 32'h44444444);

        // 5: async reset while output valid
        ctrl_valid = 4'b0001; outs_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t5_valid", outs_valid, 0);
        chk("t5_outs",  outs, 0);
        chk("t5_rdy",   ctrl_ready, 0);
        step();
        rst = 1'b0;
        ctrl_valid = 4'b1000; outs_ready = 1'b1;
        #1;
        chk("t5_rdy2", ctrl_ready, 4'b1000);
        step();
        chk("t5_outs2", outs, 0);
        chk("t5_idx2",  outs_idx, 3);
        chk("t5_vld2",  outs_valid, 1);
        ctrl_valid = 4'b0100;
        step();
        chk("t5_slot2", outs, 0);
        chk("t5_idx3",  outs_idx, 2);
        ctrl_valid = '0;
        step();
        chk("t5_drain", outs_valid, 0);

        // 6: random traffic against a reference model
        m_ptr = 3; m_valid = 1'b0; m_outs = '0; m_idx = 2'd2;
        for (int i = 0; i < N; i++) begin m_slot[i] = '0; waitc[i] = 0; end
        pend = '0; n_grant = 0; n_cons = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i]) pend[i] = ($urandom_range(0, 99) < 40);
            ctrl_valid = pend;
            outs_ready = ($urandom_range(0, 99) < 70);
            cfg_we     = ($urandom_range(0, 99) < 10);
            cfg_addr   = IW'($urandom_range(0, N - 1));
            cfg_data   = $urandom;
            #1;
            m_load = !m_valid || outs_ready;
            found = 1'b0; g = 0;
            for (int k = 0; k < N; k++) begin
                p = (m_ptr + k) % N;
                if (!found && ctrl_valid[p]) begin found = 1'b1; g = p; end
            end
            exp_rdy = (m_load && found) ? N'(1 << g) : '0;
            chk("rnd_rdy", ctrl_ready, exp_rdy);
            if (m_valid && outs_ready) n_cons++;
            if (m_load) begin
                if (found) begin
                    m_outs = m_slot[g]; m_idx = IW'(g); m_valid = 1'b1;
                    m_ptr = (g + 1) % N;
                    pend[g] = 1'b0;
                    n_grant++;
                    for (int j = 0; j < N; j++) begin
                        if (j != g && pend[j]) begin
                            waitc[j]++;
                            chk("rnd_wait", waitc[j] <= N - 1, 1);
                        end
                    end
                    waitc[g] = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (cfg_we) m_slot[cfg_addr] = cfg_data;
            step();
            chk("rnd_valid", outs_valid, m_valid);
            if (m_valid) begin
                chk("rnd_outs", outs, m_outs);
                chk("rnd_idx",  outs_idx, m_idx);
            end
        end
        cfg_we = 1'b0;
        chk("rnd_tokens", n_grant, n_cons + int'(m_valid));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
